// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants and types for the snake engine
package snake_pkg;

    localparam int         GRID_CELLS = 15;
    localparam logic [7:0] LFSR_SEED  = 8'hA5;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_FOOD  = 2'b01,
        CELL_SNAKE = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic [3:0] {
        INIT, IDLE, STEP, SCAN, ERASE, HEAD, FOOD_GEN, FOOD_SCAN, FOOD_WR, DEAD
    } state_t;

    // Opposite headings differ only in the upper bit of the code.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a ^ 2'b10) == b;
    endfunction

endpackage

// File: rtl/snake_lfsr.sv
// rtl/snake_lfsr.sv - free-running 8-bit Fibonacci LFSR for food placement
module snake_lfsr
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic fb;

    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    // Shift every clock; polynomial x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk) begin
        if (rst) q <= LFSR_SEED;
        else     q <= {q[6:0], fb};
    end

endmodule

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake game engine: body buffer, move/collision FSM, grid writes
module snake_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int GRID    = GRID_CELLS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    output logic       wr_en,
    output logic [3:0] wr_x,
    output logic [3:0] wr_y,
    output logic [1:0] wr_data,
    output logic       busy,
    output logic       game_over,
    output logic [5:0] score
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;

    typedef logic [PW-1:0] ptr_t;

    state_t        state;
    logic [1:0]    init_cnt;
    dir_t          heading;
    dir_t          pending;
    logic [3:0]    body_x [MAX_LEN];
    logic [3:0]    body_y [MAX_LEN];
    ptr_t          head_ptr;
    ptr_t          tail_ptr;
    ptr_t          scan_ptr;
    logic [LW-1:0] length;
    logic [LW-1:0] scan_cnt;
    logic [3:0]    next_x, next_y;
    logic [3:0]    food_x, food_y;
    logic [3:0]    cand_x, cand_y;
    logic          grow;
    logic [7:0]    lfsr;

    logic [3:0]    hx, hy, sx, sy;
    logic [3:0]    step_x, step_y;
    logic          eat;

    snake_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign hx = body_x[head_ptr];
    assign hy = body_y[head_ptr];
    assign sx = body_x[scan_ptr];
    assign sy = body_y[scan_ptr];

    // Candidate head one cell along the heading, wrapping at the grid edges.
    always_comb begin
        step_x = hx;
        step_y = hy;
        case (heading)
            DIR_RIGHT: step_x = (hx == 4'(GRID)) ? 4'd1 : hx + 4'd1;
            DIR_DOWN:  step_y = (hy == 4'(GRID)) ? 4'd1 : hy + 4'd1;
            DIR_LEFT:  step_x = (hx == 4'd1) ? 4'(GRID) : hx - 4'd1;
            default:   step_y = (hy == 4'd1) ? 4'(GRID) : hy - 4'd1;
        endcase
        // A full buffer cannot grow, so food is then treated as an ordinary cell.
        eat = (step_x == food_x) && (step_y == food_y) && (length != LW'(MAX_LEN));
    end

    // Main FSM with registered grid-write, busy and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_cnt  <= 2'd0;
            heading   <= DIR_RIGHT;
            pending   <= DIR_RIGHT;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            scan_ptr  <= '0;
            length    <= '0;
            scan_cnt  <= '0;
            next_x    <= 4'd0;
            next_y    <= 4'd0;
            food_x    <= 4'd0;
            food_y    <= 4'd0;
            cand_x    <= 4'd0;
            cand_y    <= 4'd0;
            grow      <= 1'b0;
            wr_en     <= 1'b0;
            wr_x      <= 4'd0;
            wr_y      <= 4'd0;
            wr_data   <= CELL_EMPTY;
            busy      <= 1'b0;
            game_over <= 1'b0;
            score     <= 6'd0;
        end else begin
            wr_en <= 1'b0;
            busy  <= 1'b1;
            if (dir_valid && state != DEAD && !is_reverse(dir_t'(dir), heading))
                pending <= dir_t'(dir);

            case (state)
                INIT: begin
                    wr_en    <= 1'b1;
                    init_cnt <= init_cnt + 2'd1;
                    case (init_cnt)
                        2'd0: begin
                            wr_x <= 4'd1; wr_y <= 4'd1; wr_data <= CELL_SNAKE;
                            body_x[0] <= 4'd1; body_y[0] <= 4'd1;
                        end
                        2'd1: begin
                            wr_x <= 4'd2; wr_y <= 4'd1; wr_data <= CELL_SNAKE;
                            body_x[1] <= 4'd2; body_y[1] <= 4'd1;
                        end
                        2'd2: begin
                            wr_x <= 4'd3; wr_y <= 4'd1; wr_data <= CELL_SNAKE;
                            body_x[2] <= 4'd3; body_y[2] <= 4'd1;
                        end
                        default: begin
                            wr_x <= 4'd8; wr_y <= 4'd8; wr_data <= CELL_FOOD;
                            food_x   <= 4'd8;
                            food_y   <= 4'd8;
                            head_ptr <= ptr_t'(2);
                            tail_ptr <= '0;
                            length   <= LW'(3);
                            state    <= IDLE;
                        end
                    endcase
                end
                IDLE: begin
                    busy <= 1'b0;
                    if (tick) begin
                        heading <= pending;
                        busy    <= 1'b1;
                        state   <= STEP;
                    end
                end
                STEP: begin
                    next_x   <= step_x;
                    next_y   <= step_y;
                    grow     <= eat;
                    // The tail cell is vacated on a plain move, so it only counts when growing.
                    scan_ptr <= eat ? tail_ptr : tail_ptr + 1'b1;
                    scan_cnt <= eat ? length : length - 1'b1;
                    state    <= SCAN;
                end
                SCAN: begin
                    if (sx == next_x && sy == next_y) begin
                        game_over <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DEAD;
                    end else if (scan_cnt == LW'(1)) begin
                        state <= grow ? HEAD : ERASE;
                    end else begin
                        scan_ptr <= scan_ptr + 1'b1;
                        scan_cnt <= scan_cnt - 1'b1;
                    end
                end
                ERASE: begin
                    wr_en    <= 1'b1;
                    wr_x     <= body_x[tail_ptr];
                    wr_y     <= body_y[tail_ptr];
                    wr_data  <= CELL_EMPTY;
                    tail_ptr <= tail_ptr + 1'b1;
                    state    <= HEAD;
                end
                HEAD: begin
                    wr_en    <= 1'b1;
                    wr_x     <= next_x;
                    wr_y     <= next_y;
                    wr_data  <= CELL_SNAKE;
                    head_ptr <= head_ptr + 1'b1;
                    body_x[ptr_t'(head_ptr + 1'b1)] <= next_x;
                    body_y[ptr_t'(head_ptr + 1'b1)] <= next_y;
                    if (grow) begin
                        length <= length + 1'b1;
                        score  <= score + 6'd1;
                        state  <= FOOD_GEN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                FOOD_GEN: begin
                    if (lfsr[3:0] != 4'd0 && lfsr[7:4] != 4'd0) begin
                        cand_x   <= lfsr[3:0];
                        cand_y   <= lfsr[7:4];
                        scan_ptr <= tail_ptr;
                        scan_cnt <= length;
                        state    <= FOOD_SCAN;
                    end
                end
                FOOD_SCAN: begin
                    if (sx == cand_x && sy == cand_y) begin
                        state <= FOOD_GEN;
                    end else if (scan_cnt == LW'(1)) begin
                        state <= FOOD_WR;
                    end else begin
                        scan_ptr <= scan_ptr + 1'b1;
                        scan_cnt <= scan_cnt - 1'b1;
                    end
                end
                FOOD_WR: begin
                    wr_en   <= 1'b1;
                    wr_x    <= cand_x;
                    wr_y    <= cand_y;
                    wr_data <= CELL_FOOD;
                    food_x  <= cand_x;
                    food_y  <= cand_y;
                    state   <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    game_over <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - scoreboard bench for snake_engine
module tb_snake_engine;

    localparam int MAX_LEN = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       wr_en;
    logic [3:0] wr_x, wr_y;
    logic [1:0] wr_data;
    logic       busy;
    logic       game_over;
    logic [5:0] score;

    snake_engine #(.MAX_LEN(MAX_LEN), .GRID(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .dir_valid (dir_valid),
        .dir       (dir),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .busy      (busy),
        .game_over (game_over),
        .score     (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
        bit any;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  bx[$];
    int  by[$];
    int  hd, pend, food_x, food_y, m_score;
    bit  m_dead;
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  wr_cyc[$];
    int  last_hx = 0;
    int  last_hy = 0;
    bit  onb;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Pop one expected write per observed write and compare it.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cyc.push_back(cyc);
            if (wr_data == 2'b10) begin
                last_hx = int'(wr_x);
                last_hy = int'(wr_y);
            end
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                if (e.any) begin
                    check_eq("food_data", int'(wr_data), 1);
                    check_eq("food_x_range", int'(wr_x >= 1 && wr_x <= 15), 1);
                    check_eq("food_y_range", int'(wr_y >= 1 && wr_y <= 15), 1);
                    onb = 0;
                    for (int i = 0; i < bx.size(); i++)
                        if (bx[i] == int'(wr_x) && by[i] == int'(wr_y)) onb = 1;
                    check_eq("food_off_body", int'(onb), 0);
                    food_x = int'(wr_x);
                    food_y = int'(wr_y);
                end else begin
                    check_eq("wr_x", int'(wr_x), e.x);
                    check_eq("wr_y", int'(wr_y), e.y);
                    check_eq("wr_data", int'(wr_data), e.d);
                end
            end
        end
    end

    task automatic model_move();
        int hx, hy, nx, ny, start;
        bit grow, hit;
        hx = bx[bx.size()-1];
        hy = by[by.size()-1];
        nx = hx;
        ny = hy;
        hd = pend;
        case (hd)
            0: nx = (hx == 15) ? 1 : hx + 1;
            1: ny = (hy == 15) ? 1 : hy + 1;
            2: nx = (hx == 1) ? 15 : hx - 1;
            default: ny = (hy == 1) ? 15 : hy - 1;
        endcase
        grow = (nx == food_x) && (ny == food_y) && (bx.size() != MAX_LEN);
        hit = 0;
        start = grow ? 0 : 1;
        for (int i = start; i < bx.size(); i++)
            if (bx[i] == nx && by[i] == ny) hit = 1;
        if (hit) begin
            m_dead = 1;
            return;
        end
        if (!grow) begin
            exp_q.push_back('{bx[0], by[0], 0, 1'b0});
            void'(bx.pop_front());
            void'(by.pop_front());
        end
        exp_q.push_back('{nx, ny, 2, 1'b0});
        bx.push_back(nx);
        by.push_back(ny);
        if (grow) begin
            m_score++;
            exp_q.push_back('{0, 0, 1, 1'b1});
        end
    endtask

    task automatic send_dir(input int d);
        if (!m_dead && ((d ^ 2) != hd)) pend = d;
        @(negedge clk);
        dir_valid = 1'b1;
        dir = 2'(d);
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    task automatic do_tick();
        int n;
        if (!m_dead) model_move();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("move_done_busy", int'(busy), 0);
        check_eq("exp_drained", exp_q.size(), 0);
        check_eq("score", int'(score), m_score);
        check_eq("game_over", int'(game_over), int'(m_dead));
    endtask

    task automatic do_reset();
        int n;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_wr_en", int'(wr_en), 0);
        check_eq("rst_wr_x", int'(wr_x), 0);
        check_eq("rst_wr_y", int'(wr_y), 0);
        check_eq("rst_wr_data", int'(wr_data), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_game_over", int'(game_over), 0);
        check_eq("rst_score", int'(score), 0);
        exp_q.delete();
        bx = '{1, 2, 3};
        by = '{1, 1, 1};
        hd = 0;
        pend = 0;
        food_x = 8;
        food_y = 8;
        m_score = 0;
        m_dead = 0;
        exp_q.push_back('{1, 1, 2, 1'b0});
        exp_q.push_back('{2, 1, 2, 1'b0});
        exp_q.push_back('{3, 1, 2, 1'b0});
        exp_q.push_back('{8, 8, 1, 1'b0});
        wr_cyc.delete();
        rst = 1'b0;
        @(negedge clk);
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("init_busy", int'(busy), 0);
        check_eq("init_drained", exp_q.size(), 0);
        check_eq("init_count", wr_cyc.size(), 4);
        if (wr_cyc.size() == 4) check_eq("init_consecutive", wr_cyc[3] - wr_cyc[0], 3);
    endtask

    task automatic go_to_food();
        int target, d, hx, hy;
        target = m_score + 1;
        for (int k = 0; k < 80; k++) begin
            if (m_dead || m_score >= target) break;
            hx = bx[bx.size()-1];
            hy = by[by.size()-1];
            if (hx != food_x) begin
                d = (food_x > hx) ? 0 : 2;
                if ((d ^ 2) == hd) d = 1;
            end else begin
                d = (food_y > hy) ? 1 : 3;
                if ((d ^ 2) == hd) d = 0;
            end
            if (d != hd) send_dir(d);
            do_tick();
        end
        check_eq("food_reached", m_score, target);
    endtask

    initial begin
        do_reset();

        do_tick();
        check_eq("first_head_x", last_hx, 4);
        check_eq("first_head_y", last_hy, 1);

        send_dir(2);
        do_tick();
        check_eq("rev_head_x", last_hx, 5);
        check_eq("rev_head_y", last_hy, 1);

        send_dir(1);
        for (int i = 0; i < 4; i++) do_tick();
        send_dir(0);
        for (int i = 0; i < 10; i++) do_tick();
        check_eq("edge_head_x", last_hx, 15);
        do_tick();
        check_eq("wrap_head_x", last_hx, 1);
        check_eq("wrap_head_y", last_hy, 5);

        go_to_food();
        check_eq("score_one", int'(score), 1);
        go_to_food();
        check_eq("len_five", bx.size(), 5);

        for (int i = 0; i < 3; i++) begin
            send_dir((hd + 1) % 4);
            do_tick();
        end
        check_eq("dead_flag", int'(game_over), 1);

        send_dir((hd + 1) % 4);
        do_tick();
        do_tick();
        check_eq("dead_sticky", int'(game_over), 1);

        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
